stopwatch_time_counter: RTL

Datapath end of the stopwatch control interface. It consumes the run and clr levels from the stopwatch controller FSM and keeps elapsed time as BCD mm:ss.cc, advancing one centisecond per prescaled tick. It also provides a lap-hold function: the display outputs freeze on a captured value while the live count keeps running. Outputs feed the 7-segment display driver.

---
 rtl/stopwatch_time_counter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_time_counter.sv
// Stopwatch datapath: prescaled BCD mm:ss.cc time counter with lap-hold display snapshot.
// Display outputs are registered from next-state values so they track hold/live with no extra latency.
module stopwatch_time_counter #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int TICK_HZ     = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       clr,
   input  logic       lap,
   output logic [3:0] cs_ones,
   output logic [3:0] cs_tens,
   output logic [3:0] s_ones,
   output logic [3:0] s_tens,
   output logic [3:0] m_ones,
   output logic [3:0] m_tens,
   output logic       hold,
   output logic       tick,
   output logic       wrap
);

   localparam int DIV     = CLK_FREQ_HZ / TICK_HZ;
   localparam int PRESC_W = (DIV >= 2) ? $clog2(DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
   localparam logic [23:0]        FULL_TIME  = 24'h595999;

   generate
      if ((DIV < 2) || ((CLK_FREQ_HZ % TICK_HZ) != 0)) begin : g_div_check
         $error("stopwatch_time_counter: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
      end
   endgenerate

   // Terminal value of digit i in the packed {mt,mo,st,so,ct,co} word.
   function automatic logic [3:0] digit_max(input int i);
      return ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
   endfunction

   // One-centisecond BCD increment with ripple carry; out-of-range digits recover to 0.
   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [23:0] r;
      logic        carry;
      r     = t;
      carry = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (carry) begin
            if (t[i*4 +: 4] >= digit_max(i)) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end else begin
            r[i*4 +: 4] = t[i*4 +: 4];
         end
      end
      return r;
   endfunction

   logic [PRESC_W-1:0] presc_r, presc_n;
   logic [23:0]        live_r, live_n;
   logic [23:0]        snap_r, snap_n;
   logic [23:0]        disp_r, disp_n;
   logic               hold_r, hold_n;
   logic               tick_r, tick_n;
   logic               wrap_r, wrap_n;
   logic               lap_q_r;
   logic               lap_evt_s;

   assign lap_evt_s = lap & ~lap_q_r;

   // Next-state: clear dominates; otherwise prescale/advance and handle lap toggling.
   always_comb begin
      presc_n = presc_r;
      live_n  = live_r;
      snap_n  = snap_r;
      hold_n  = hold_r;
      wrap_n  = wrap_r;
      tick_n  = 1'b0;
      if (clr) begin
         presc_n = '0;
         live_n  = 24'h000000;
         snap_n  = 24'h000000;
         hold_n  = 1'b0;
         wrap_n  = 1'b0;
         tick_n  = 1'b0;
      end else begin
         if (run) begin
            if (presc_r == PRESC_LAST) begin
               presc_n = '0;
               live_n  = bcd_inc(live_r);
               tick_n  = 1'b1;
               if (live_r == FULL_TIME) begin
                  wrap_n = 1'b1;
               end else begin
                  wrap_n = wrap_r;
               end
            end else begin
               presc_n = presc_r + PRESC_W'(1);
            end
         end else begin
            presc_n = presc_r;
         end
         // Snapshot uses the pre-edge live value even when a tick coincides.
         if (lap_evt_s) begin
            if (!hold_r) begin
               snap_n = live_r;
               hold_n = 1'b1;
            end else begin
               hold_n = 1'b0;
            end
         end else begin
            hold_n = hold_r;
         end
      end
   end

   // Display source selection on next-state values.
   always_comb begin
      disp_n = 24'h000000;
      if (hold_n) begin
         disp_n = snap_n;
      end else begin
         disp_n = live_n;
      end
   end

   // State and output registers; lap edge register samples every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_r <= '0;
         live_r  <= 24'h000000;
         snap_r  <= 24'h000000;
         disp_r  <= 24'h000000;
         hold_r  <= 1'b0;
         tick_r  <= 1'b0;
         wrap_r  <= 1'b0;
         lap_q_r <= 1'b0;
      end else begin
         presc_r <= presc_n;
         live_r  <= live_n;
         snap_r  <= snap_n;
         disp_r  <= disp_n;
         hold_r  <= hold_n;
         tick_r  <= tick_n;
         wrap_r  <= wrap_n;
         lap_q_r <= lap;
      end
   end

   assign cs_ones = disp_r[3:0];
   assign cs_tens = disp_r[7:4];
   assign s_ones  = disp_r[11:8];
   assign s_tens  = disp_r[15:12];
   assign m_ones  = disp_r[19:16];
   assign m_tens  = disp_r[23:20];
   assign hold    = hold_r;
   assign tick    = tick_r;
   assign wrap    = wrap_r;

endmodule
